// File: rtl/dm_mem_arbiter_pkg.sv
// Shared types and default hart-side address map for the Debug Module storage arbiter.
package dm_mem_arbiter_pkg;

    typedef enum logic {
        MemData    = 1'b0,
        MemProgBuf = 1'b1
    } mem_sel_e;

    typedef enum logic [1:0] {
        OwnIdle = 2'd0,
        OwnDmi  = 2'd1,
        OwnHart = 2'd2
    } arb_owner_e;

    localparam logic [31:0] DefDataAddr    = 32'h380;
    localparam logic [31:0] DefProgBufAddr = 32'h360;

endpackage

// File: rtl/dm_mem_addr_decode.sv
// Maps a hart-side byte address onto the DM data/progbuf storage index.
module dm_mem_addr_decode
    import dm_mem_arbiter_pkg::*;
#(
    parameter int unsigned         DataCount   = 12,
    parameter int unsigned         ProgBufSize = 16,
    parameter int unsigned         BusWidth    = 32,
    parameter logic [BusWidth-1:0] DataAddr    = BusWidth'(DefDataAddr),
    parameter logic [BusWidth-1:0] ProgBufAddr = BusWidth'(DefProgBufAddr)
) (
    input  logic [BusWidth-1:0] addr,
    input  logic                we,
    output logic                hit,
    output mem_sel_e            sel,
    output logic [4:0]          idx,
    output logic                progbuf_write_drop
);

    localparam logic [BusWidth-1:0] DataEnd    = DataAddr + BusWidth'(4 * DataCount);
    localparam logic [BusWidth-1:0] ProgBufEnd = ProgBufAddr + BusWidth'(4 * ProgBufSize);

    logic [BusWidth-1:0] data_off;
    logic [BusWidth-1:0] pb_off;

    assign data_off = addr - DataAddr;
    assign pb_off   = addr - ProgBufAddr;

    // The two windows may overlap; the data window takes priority.
    always_comb begin
        // NOTE: every always_comb output is given a default first so no path can infer a latch.
        hit                = 1'b0;
        sel                = MemData;
        idx                = '0;
        progbuf_write_drop = 1'b0;
        if (addr >= DataAddr && addr < DataEnd) begin
            hit = 1'b1;
            idx = 5'(data_off >> 2);
        end else if (addr >= ProgBufAddr && addr < ProgBufEnd) begin
            hit                = 1'b1;
            sel                = MemProgBuf;
            idx                = 5'(pb_off >> 2);
            progbuf_write_drop = we;
        end
    end

endmodule

// File: rtl/dm_mem_arbiter.sv
// Shares the DM data/progbuf storage port between the DMI and hart requesters,
// returning 1-cycle read data to whichever side owned the access.
module dm_mem_arbiter
    import dm_mem_arbiter_pkg::*;
#(
    parameter int unsigned         DataCount   = 12,
    parameter int unsigned         ProgBufSize = 16,
    parameter int unsigned         BusWidth    = 32,
    parameter logic [BusWidth-1:0] DataAddr    = BusWidth'(DefDataAddr),
    parameter logic [BusWidth-1:0] ProgBufAddr = BusWidth'(DefProgBufAddr),
    parameter int unsigned         StarveLimit = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   dmactive_i,
    input  logic                   cmdbusy_i,
    input  logic [DataCount-1:0]   autoexecdata_i,
    input  logic [ProgBufSize-1:0] autoexecprogbuf_i,
    input  logic                   dmi_req_valid_i,
    output logic                   dmi_req_ready_o,
    input  logic                   dmi_we_i,
    input  logic                   dmi_sel_i,
    input  logic [4:0]             dmi_idx_i,
    input  logic [31:0]            dmi_wdata_i,
    output logic                   dmi_rvalid_o,
    output logic [31:0]            dmi_rdata_o,
    output logic                   dmi_busy_err_o,
    output logic                   autoexec_o,
    input  logic                   hart_req_i,
    input  logic                   hart_we_i,
    input  logic [BusWidth-1:0]    hart_addr_i,
    input  logic [BusWidth-1:0]    hart_wdata_i,
    output logic                   hart_gnt_o,
    output logic                   hart_rvalid_o,
    output logic [BusWidth-1:0]    hart_rdata_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic                   mem_sel_o,
    output logic [4:0]             mem_idx_o,
    output logic [31:0]            mem_wdata_o,
    input  logic [31:0]            mem_rdata_i
);

    localparam int unsigned     CntW   = $clog2(StarveLimit + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(StarveLimit);

    logic            dmi_req, hart_req, dmi_win, hart_win;
    logic            dmi_in_range, dmi_mem_ok, dmi_ae, hart_mem_ok;
    logic            hart_hit, hart_drop;
    mem_sel_e        hart_sel;
    logic [4:0]      hart_idx;
    logic [31:0]     ae_data, ae_pb;
    logic [CntW-1:0] dmi_cnt, hart_cnt;
    arb_owner_e      owner_q, owner_d;
    logic            resp_mem_q, resp_mem_d;
    logic            resp_err_q, resp_err_d;
    logic            resp_auto_q, resp_auto_d;

    dm_mem_addr_decode #(
        .DataCount  (DataCount),
        .ProgBufSize(ProgBufSize),
        .BusWidth   (BusWidth),
        .DataAddr   (DataAddr),
        .ProgBufAddr(ProgBufAddr)
    ) u_decode (
        .addr              (hart_addr_i),
        .we                (hart_we_i),
        .hit               (hart_hit),
        .sel               (hart_sel),
        .idx               (hart_idx),
        .progbuf_write_drop(hart_drop)
    );

    assign ae_data      = 32'(autoexecdata_i);
    assign ae_pb        = 32'(autoexecprogbuf_i);
    assign dmi_in_range = dmi_sel_i ? ({1'b0, dmi_idx_i} < 6'(ProgBufSize))
                                    : ({1'b0, dmi_idx_i} < 6'(DataCount));
    assign dmi_mem_ok   = dmi_in_range & ~cmdbusy_i;
    assign dmi_ae       = dmi_sel_i ? ae_pb[dmi_idx_i] : ae_data[dmi_idx_i];
    assign hart_mem_ok  = hart_hit & ~hart_drop;

    // Busy favours the hart, idle favours the debugger; a starved loser overrides.
    always_comb begin
        dmi_req  = dmi_req_valid_i & dmactive_i & ~rst_i;
        hart_req = hart_req_i & dmactive_i & ~rst_i;
        dmi_win  = dmi_req;
        hart_win = hart_req;
        if (dmi_req && hart_req) begin
            hart_win = cmdbusy_i ? (dmi_cnt != CntMax) : (hart_cnt == CntMax);
            dmi_win  = ~hart_win;
        end
    end

    assign dmi_req_ready_o = dmi_win;
    assign hart_gnt_o      = hart_win;

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_sel_o   = 1'b0;
        mem_idx_o   = '0;
        mem_wdata_o = '0;
        if (dmi_win && dmi_mem_ok) begin
            mem_req_o   = 1'b1;
            mem_we_o    = dmi_we_i;
            mem_sel_o   = dmi_sel_i;
            mem_idx_o   = dmi_idx_i;
            mem_wdata_o = dmi_wdata_i;
        end else if (hart_win && hart_mem_ok) begin
            mem_req_o   = 1'b1;
            mem_we_o    = hart_we_i;
            mem_sel_o   = hart_sel;
            mem_idx_o   = hart_idx;
            mem_wdata_o = 32'(hart_wdata_i);
        end
    end

    always_comb begin
        owner_d     = OwnIdle;
        resp_mem_d  = 1'b0;
        resp_err_d  = 1'b0;
        resp_auto_d = 1'b0;
        if (dmi_win) begin
            owner_d     = OwnDmi;
            resp_mem_d  = dmi_mem_ok & ~dmi_we_i;
            resp_err_d  = cmdbusy_i;
            resp_auto_d = dmi_mem_ok & dmi_ae;
        end else if (hart_win) begin
            owner_d    = OwnHart;
            resp_mem_d = hart_mem_ok & ~hart_we_i;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            owner_q     <= OwnIdle;
            resp_mem_q  <= 1'b0;
            resp_err_q  <= 1'b0;
            resp_auto_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            resp_mem_q  <= resp_mem_d;
            resp_err_q  <= resp_err_d;
            resp_auto_q <= resp_auto_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !dmactive_i) begin
            dmi_cnt  <= '0;
            hart_cnt <= '0;
        end else begin
            if (dmi_req_valid_i && !dmi_win) begin
                if (dmi_cnt != CntMax) dmi_cnt <= dmi_cnt + CntW'(1);
            end else begin
                dmi_cnt <= '0;
            end
            if (hart_req_i && !hart_win) begin
                if (hart_cnt != CntMax) hart_cnt <= hart_cnt + CntW'(1);
            end else begin
                hart_cnt <= '0;
            end
        end
    end

    // Responses are held back while reset is asserted so nothing leaks out mid-reset.
    always_comb begin
        dmi_rvalid_o   = 1'b0;
        dmi_rdata_o    = '0;
        dmi_busy_err_o = 1'b0;
        autoexec_o     = 1'b0;
        hart_rvalid_o  = 1'b0;
        hart_rdata_o   = '0;
        if (!rst_i) begin
            unique case (owner_q)
                OwnDmi: begin
                    dmi_rvalid_o   = 1'b1;
                    dmi_rdata_o    = resp_mem_q ? mem_rdata_i : '0;
                    dmi_busy_err_o = resp_err_q;
                    autoexec_o     = resp_auto_q;
                end
                OwnHart: begin
                    hart_rvalid_o = 1'b1;
                    hart_rdata_o  = resp_mem_q ? BusWidth'(mem_rdata_i) : '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_mem_arbiter.sv
// Directed and random stimulus for dm_mem_arbiter, checked against a rule-level model
// with its own copy of the storage contents.
module tb_dm_mem_arbiter;

    localparam int          DataCount   = 12;
    localparam int          ProgBufSize = 16;
    localparam int          StarveLimit = 4;
    localparam logic [31:0] DataBase    = 32'h380;
    localparam logic [31:0] PbBase      = 32'h360;

    logic        clk, rst_i, dmactive_i, cmdbusy_i;
    logic [11:0] autoexecdata_i;
    logic [15:0] autoexecprogbuf_i;
    logic        dmi_req_valid_i, dmi_req_ready_o, dmi_we_i, dmi_sel_i;
    logic [4:0]  dmi_idx_i;
    logic [31:0] dmi_wdata_i;
    logic        dmi_rvalid_o;
    logic [31:0] dmi_rdata_o;
    logic        dmi_busy_err_o, autoexec_o;
    logic        hart_req_i, hart_we_i;
    logic [31:0] hart_addr_i, hart_wdata_i;
    logic        hart_gnt_o, hart_rvalid_o;
    logic [31:0] hart_rdata_o;
    logic        mem_req_o, mem_we_o, mem_sel_o;
    logic [4:0]  mem_idx_o;
    logic [31:0] mem_wdata_o, mem_rdata_i;

    dm_mem_arbiter #(
        .DataCount  (DataCount),
        .ProgBufSize(ProgBufSize),
        .BusWidth   (32),
        .DataAddr   (DataBase),
        .ProgBufAddr(PbBase),
        .StarveLimit(StarveLimit)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .dmactive_i       (dmactive_i),
        .cmdbusy_i        (cmdbusy_i),
        .autoexecdata_i   (autoexecdata_i),
        .autoexecprogbuf_i(autoexecprogbuf_i),
        .dmi_req_valid_i  (dmi_req_valid_i),
        .dmi_req_ready_o  (dmi_req_ready_o),
        .dmi_we_i         (dmi_we_i),
        .dmi_sel_i        (dmi_sel_i),
        .dmi_idx_i        (dmi_idx_i),
        .dmi_wdata_i      (dmi_wdata_i),
        .dmi_rvalid_o     (dmi_rvalid_o),
        .dmi_rdata_o      (dmi_rdata_o),
        .dmi_busy_err_o   (dmi_busy_err_o),
        .autoexec_o       (autoexec_o),
        .hart_req_i       (hart_req_i),
        .hart_we_i        (hart_we_i),
        .hart_addr_i      (hart_addr_i),
        .hart_wdata_i     (hart_wdata_i),
        .hart_gnt_o       (hart_gnt_o),
        .hart_rvalid_o    (hart_rvalid_o),
        .hart_rdata_o     (hart_rdata_o),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .mem_sel_o        (mem_sel_o),
        .mem_idx_o        (mem_idx_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_rdata_i      (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference contents (model) and the storage the DUT actually talks to (stub).
    logic [31:0] ref_data [DataCount];
    logic [31:0] ref_pb   [ProgBufSize];
    logic [31:0] stub_data[DataCount];
    logic [31:0] stub_pb  [ProgBufSize];

    int          dmi_starve, hart_starve;
    bit          p_dmi, p_hart, p_err, p_auto;
    logic [31:0] p_dmi_rdata, p_hart_rdata;
    bit          s_rd, s_sel;
    int          s_idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void hart_decode(input logic [31:0] a, output bit hit, output bit sel,
                                        output int idx);
        hit = 1'b0;
        sel = 1'b0;
        idx = 0;
        if (a >= DataBase && a < DataBase + 32'(4 * DataCount)) begin
            hit = 1'b1;
            idx = int'((a - DataBase) >> 2);
        end else if (a >= PbBase && a < PbBase + 32'(4 * ProgBufSize)) begin
            hit = 1'b1;
            sel = 1'b1;
            idx = int'((a - PbBase) >> 2);
        end
    endfunction

    task automatic cycle(input bit rst, input bit act, input bit busy,
                         input logic [11:0] aed, input logic [15:0] aep,
                         input bit dv, input bit dwe, input bit dsel, input logic [4:0] didx,
                         input logic [31:0] dwd,
                         input bit hreq, input bit hwe, input logic [31:0] haddr,
                         input logic [31:0] hwd, output bit hart_granted);
        bit          dr, hr, dwin, hwin, din, dmem, hhit, hsel, hmem, e_req, e_we, e_sel;
        int          hidx, di, e_idx;
        logic [31:0] e_wd;

        @(posedge clk);
        #1;
        if (s_rd) mem_rdata_i = s_sel ? stub_pb[s_idx] : stub_data[s_idx];
        else      mem_rdata_i = $urandom;
        rst_i             = rst;
        dmactive_i        = act;
        cmdbusy_i         = busy;
        autoexecdata_i    = aed;
        autoexecprogbuf_i = aep;
        dmi_req_valid_i   = dv;
        dmi_we_i          = dwe;
        dmi_sel_i         = dsel;
        dmi_idx_i         = didx;
        dmi_wdata_i       = dwd;
        hart_req_i        = hreq;
        hart_we_i         = hwe;
        hart_addr_i       = haddr;
        hart_wdata_i      = hwd;
        #1;

        // Response owed from the previous cycle's grant.
        check("dmi_rvalid", 32'(dmi_rvalid_o), 32'(!rst && p_dmi));
        check("dmi_rdata", dmi_rdata_o, (!rst && p_dmi) ? p_dmi_rdata : 32'h0);
        check("busy_err", 32'(dmi_busy_err_o), 32'(!rst && p_dmi && p_err));
        check("autoexec", 32'(autoexec_o), 32'(!rst && p_dmi && p_auto));
        check("hart_rvalid", 32'(hart_rvalid_o), 32'(!rst && p_hart));
        check("hart_rdata", hart_rdata_o, (!rst && p_hart) ? p_hart_rdata : 32'h0);

        dr   = dv && act && !rst;
        hr   = hreq && act && !rst;
        dwin = dr;
        hwin = hr;
        if (dr && hr) begin
            if (busy) begin
                if (dmi_starve == StarveLimit) hwin = 1'b0;
                else                           dwin = 1'b0;
            end else begin
                if (hart_starve == StarveLimit) dwin = 1'b0;
                else                            hwin = 1'b0;
            end
        end
        check("dmi_ready", 32'(dmi_req_ready_o), 32'(dwin));
        check("hart_gnt", 32'(hart_gnt_o), 32'(hwin));
        hart_granted = hart_gnt_o;

        di   = int'(didx);
        din  = dsel ? (di < ProgBufSize) : (di < DataCount);
        dmem = din && !busy;
        hart_decode(haddr, hhit, hsel, hidx);
        hmem = hhit && !(hwe && hsel);

        e_req = 1'b0; e_we = 1'b0; e_sel = 1'b0; e_idx = 0; e_wd = 32'h0;
        if (dwin && dmem) begin
            e_req = 1'b1; e_we = dwe; e_sel = dsel; e_idx = di; e_wd = dwd;
        end else if (hwin && hmem) begin
            e_req = 1'b1; e_we = hwe; e_sel = hsel; e_idx = hidx; e_wd = hwd;
        end
        check("mem_req", 32'(mem_req_o), 32'(e_req));
        if (e_req) begin
            check("mem_we", 32'(mem_we_o), 32'(e_we));
            check("mem_sel", 32'(mem_sel_o), 32'(e_sel));
            check("mem_idx", 32'(mem_idx_o), 32'(e_idx));
            if (e_we) check("mem_wdata", mem_wdata_o, e_wd);
        end

        // Storage stub follows what the DUT actually drove.
        s_rd = 1'b0;
        if (mem_req_o) begin
            if (mem_we_o) begin
                if (mem_sel_o) begin
                    if (int'(mem_idx_o) < ProgBufSize) stub_pb[int'(mem_idx_o)] = mem_wdata_o;
                end else if (int'(mem_idx_o) < DataCount) begin
                    stub_data[int'(mem_idx_o)] = mem_wdata_o;
                end
            end else begin
                s_rd  = mem_sel_o ? (int'(mem_idx_o) < ProgBufSize) : (int'(mem_idx_o) < DataCount);
                s_sel = mem_sel_o;
                s_idx = int'(mem_idx_o);
            end
        end

        p_dmi        = dwin;
        p_hart       = hwin;
        p_err        = busy;
        p_auto       = 1'b0;
        p_dmi_rdata  = 32'h0;
        p_hart_rdata = 32'h0;
        if (dwin && dmem) begin
            p_auto = dsel ? aep[didx[3:0]] : aed[didx[3:0]];
            if (dwe) begin
                if (dsel) ref_pb[di] = dwd;
                else      ref_data[di] = dwd;
            end else begin
                p_dmi_rdata = dsel ? ref_pb[di] : ref_data[di];
            end
        end
        if (hwin && hmem) begin
            if (hwe) ref_data[hidx] = hwd;
            else     p_hart_rdata = hsel ? ref_pb[hidx] : ref_data[hidx];
        end

        if (rst || !act) begin
            dmi_starve  = 0;
            hart_starve = 0;
        end else begin
            dmi_starve  = (dv && !dwin) ? ((dmi_starve < StarveLimit) ? dmi_starve + 1 : dmi_starve) : 0;
            hart_starve = (hreq && !hwin) ? ((hart_starve < StarveLimit) ? hart_starve + 1 : hart_starve) : 0;
        end
    endtask

    task automatic idle();
        bit g;
        cycle(0, 1, 0, 12'h0, 16'h0, 0, 0, 0, 5'd0, 32'h0, 0, 0, 32'h0, 32'h0, g);
    endtask

    initial begin
        bit          g, r, act, busy, dv, dwe, dsel, hreq, hwe;
        bit [5:0]    pat;
        logic [4:0]  didx;
        logic [31:0] haddr, v;
        logic [31:0] edge_addr[6];

        rst_i = 1'b1; dmactive_i = 1'b0; cmdbusy_i = 1'b0;
        autoexecdata_i = '0; autoexecprogbuf_i = '0;
        dmi_req_valid_i = 1'b0; dmi_we_i = 1'b0; dmi_sel_i = 1'b0; dmi_idx_i = '0; dmi_wdata_i = '0;
        hart_req_i = 1'b0; hart_we_i = 1'b0; hart_addr_i = '0; hart_wdata_i = '0;
        mem_rdata_i = '0;
        for (int i = 0; i < DataCount; i++) begin
            v = $urandom; ref_data[i] = v; stub_data[i] = v;
        end
        for (int i = 0; i < ProgBufSize; i++) begin
            v = $urandom; ref_pb[i] = v; stub_pb[i] = v;
        end
        dmi_starve = 0; hart_starve = 0;
        p_dmi = 0; p_hart = 0; p_err = 0; p_auto = 0; p_dmi_rdata = 0; p_hart_rdata = 0;
        s_rd = 0; s_sel = 0; s_idx = 0;
        repeat (2) @(posedge clk);

        // Reset held with both sides requesting: nothing granted, all outputs quiet.
        cycle(1, 1, 0, 12'hfff, 16'hffff, 1, 0, 0, 5'd1, 32'h0, 1, 0, 32'h380, 32'h0, g);
        idle();

        // DMI write with autoexec, then hart read of data[1] returning 0x11.
        cycle(0, 1, 0, 12'h008, 16'h0, 1, 1, 0, 5'd3, 32'hCAFE0003, 0, 0, 32'h0, 32'h0, g);
        idle();
        cycle(0, 1, 0, 12'h0, 16'h0, 1, 1, 0, 5'd1, 32'h11, 0, 0, 32'h0, 32'h0, g);
        cycle(0, 1, 0, 12'h0, 16'h0, 0, 0, 0, 5'd0, 32'h0, 1, 0, 32'h384, 32'h0, g);
        idle();
        check("hart_rd_0x384_model", p_dmi_rdata | ref_data[1], 32'h11);
        // Busy-error DMI read.
        cycle(0, 1, 1, 12'hfff, 16'h0, 1, 0, 0, 5'd0, 32'h0, 0, 0, 32'h0, 32'h0, g);
        idle();
        // Hart write into progbuf is dropped.
        cycle(0, 1, 0, 12'h0, 16'h0, 0, 0, 0, 5'd0, 32'h0, 1, 1, 32'h360, 32'hDEADBEEF, g);
        idle();

        // Starvation override in both arbitration directions.
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 1, 12'h0, 16'h0, 1, 0, 0, 5'd2, 32'h0, 1, 0, 32'h388, 32'h0, g);
            pat[i] = g;
        end
        check("starve_busy_pattern", 32'(pat), 32'(6'b101111));
        idle();
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 0, 12'h0, 16'h0, 1, 0, 1, 5'd4, 32'h0, 1, 0, 32'h390, 32'h0, g);
            pat[i] = g;
        end
        check("starve_idle_pattern", 32'(pat), 32'(6'b010000));
        idle();

        // Index and address boundaries.
        cycle(0, 1, 0, 12'h0, 16'hffff, 1, 0, 1, 5'd16, 32'h0, 0, 0, 32'h0, 32'h0, g);
        cycle(0, 1, 0, 12'h0, 16'hffff, 1, 0, 1, 5'd15, 32'h0, 0, 0, 32'h0, 32'h0, g);
        cycle(0, 1, 0, 12'hfff, 16'h0, 1, 0, 0, 5'd11, 32'h0, 0, 0, 32'h0, 32'h0, g);
        cycle(0, 1, 0, 12'hfff, 16'h0, 1, 0, 0, 5'd12, 32'h0, 0, 0, 32'h0, 32'h0, g);
        cycle(0, 1, 0, 12'h0, 16'h0, 0, 0, 0, 5'd0, 32'h0, 1, 0, 32'h000, 32'h0, g);
        edge_addr[0] = 32'h3AF; edge_addr[1] = 32'h3B0; edge_addr[2] = 32'h35F;
        edge_addr[3] = 32'h363; edge_addr[4] = 32'h39C; edge_addr[5] = 32'h37F;
        for (int i = 0; i < 6; i++)
            cycle(0, 1, 0, 12'h0, 16'h0, 0, 0, 0, 5'd0, 32'h0, 1, 0, edge_addr[i], 32'h0, g);
        idle();

        // Inactive DM blocks grants; a response pending across the drop still arrives.
        cycle(0, 0, 0, 12'h0, 16'h0, 1, 0, 0, 5'd2, 32'h0, 1, 0, 32'h384, 32'h0, g);
        cycle(0, 1, 0, 12'h0, 16'h0, 1, 0, 0, 5'd2, 32'h0, 0, 0, 32'h0, 32'h0, g);
        cycle(0, 0, 0, 12'h0, 16'h0, 0, 0, 0, 5'd0, 32'h0, 0, 0, 32'h0, 32'h0, g);
        // Reset right after a grant suppresses the response.
        cycle(0, 1, 0, 12'h0, 16'h0, 0, 0, 0, 5'd0, 32'h0, 1, 0, 32'h388, 32'h0, g);
        cycle(1, 1, 0, 12'hfff, 16'hffff, 1, 0, 0, 5'd2, 32'h0, 1, 0, 32'h388, 32'h0, g);
        idle();

        for (int i = 0; i < 3000; i++) begin
            r    = ($urandom_range(0, 99) == 0);
            act  = ($urandom_range(0, 19) != 0);
            busy = ($urandom_range(0, 3) == 0);
            dv   = ($urandom_range(0, 3) != 0);
            dwe  = $urandom_range(0, 1) != 0;
            dsel = $urandom_range(0, 1) != 0;
            didx = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 17));
            hreq = ($urandom_range(0, 3) != 0);
            hwe  = $urandom_range(0, 1) != 0;
            case ($urandom_range(0, 3))
                0:       haddr = DataBase + 32'($urandom_range(0, 47));
                1:       haddr = PbBase + 32'($urandom_range(0, 63));
                2:       haddr = 32'h340 + 32'($urandom_range(0, 127));
                default: haddr = $urandom;
            endcase
            cycle(r, act, busy, 12'($urandom), 16'($urandom), dv, dwe, dsel, didx, $urandom,
                  hreq, hwe, haddr, $urandom, g);
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
